// File: rtl/kernel_dist_sequencer_if.sv
// Instruction-in and control-word-out handshakes of the kernel distribution sequencer.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface kernel_dist_sequencer_if #(
  parameter int depth = 3
);
  logic [2*depth+7:0] instr_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [2*depth-1:0] controlSignal;
  logic               ctrl_valid;
  logic               ctrl_ready;

  modport master (
    input  instr_data, instr_valid, ctrl_ready,
    output instr_ready, controlSignal, ctrl_valid
  );

  modport slave (
    output instr_data, instr_valid, ctrl_ready,
    input  instr_ready, controlSignal, ctrl_valid
  );
endinterface

// File: rtl/kernel_dist_sequencer.sv
// Queues {rep, trc, bank} instructions and, after start, issues each {trc,bank} word
// rep+1 times to the KernelBufferDistributor, pulsing done when the queue drains.
module kernel_dist_sequencer #(
  parameter int depth = 3,
  parameter int QD    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  kernel_dist_sequencer_if.master bus,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(QD):0]   count,
  output logic [1:0]            state_dbg
);
  localparam int AW    = $clog2(QD);
  localparam int CNT_W = AW + 1;
  localparam int CW    = 2 * depth;
  localparam int IW    = CW + 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, count_after;
  logic [7:0]       remaining_q, remaining_d;
  logic [CW-1:0]    ctrl_q, ctrl_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic [IW-1:0]    mem_q [QD];

  logic          instr_ready_w, push, issue, pop;
  logic [IW-1:0] head_word, follow_word;

  assign instr_ready_w = (count_q < CNT_W'(QD));
  assign push          = bus.instr_valid && instr_ready_w && !abort;
  assign issue         = (state_q == S_RUN) && ctrl_valid_q && bus.ctrl_ready;
  assign pop           = issue && (remaining_q == 8'd0);
  assign count_after   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head_word     = mem_q[rd_ptr_q];
  // With only the head queued, the follower is the word being pushed this very cycle.
  assign follow_word   = (count_q > CNT_W'(1)) ? mem_q[rd_ptr_q + AW'(1)] : bus.instr_data;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_after;
    remaining_d  = remaining_q;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = ctrl_valid_q;
    if (abort) begin
      state_d      = S_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      remaining_d  = 8'd0;
      ctrl_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ctrl_valid_d = 1'b0;
          if (start && (count_q != '0)) begin
            state_d      = S_RUN;
            ctrl_d       = head_word[CW-1:0];
            remaining_d  = head_word[IW-1:CW];
            ctrl_valid_d = 1'b1;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (remaining_q != 8'd0) begin
              remaining_d = remaining_q - 8'd1;
            end else if (count_after != '0) begin
              ctrl_d      = follow_word[CW-1:0];
              remaining_d = follow_word[IW-1:CW];
            end else begin
              state_d      = S_DONE;
              ctrl_valid_d = 1'b0;
            end
          end
        end
        S_DONE: begin
          state_d      = S_IDLE;
          ctrl_valid_d = 1'b0;
        end
        default: begin
          state_d      = S_IDLE;
          ctrl_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      remaining_q  <= 8'd0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.instr_data;
  end

  assign bus.instr_ready   = instr_ready_w;
  assign bus.controlSignal = ctrl_q;
  assign bus.ctrl_valid    = ctrl_valid_q;
  assign busy              = (state_q == S_RUN);
  assign done              = (state_q == S_DONE);
  assign count             = count_q;
  assign state_dbg         = state_q;
endmodule

// File: tb/tb_kernel_dist_sequencer.sv
// Bench for kernel_dist_sequencer: vector table of single-instruction runs plus
// hand-written sequences for the multi-cycle corner cases, with an issue scoreboard.
`timescale 1ns/1ps
module tb_kernel_dist_sequencer;
  localparam int DEPTH = 3;
  localparam int QD    = 8;
  localparam int CW    = 2 * DEPTH;

  logic CLK;
  logic RST_N;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [$clog2(QD):0] count;
  logic [1:0] state_dbg;

  kernel_dist_sequencer_if #(.depth(DEPTH)) bus ();

  kernel_dist_sequencer #(.depth(DEPTH), .QD(QD)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus.master),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int issue_cnt = 0;
  int done_cnt = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [7:0] rep, input logic [CW-1:0] ctrl);
    for (int i = 0; i <= int'(rep); i++) exp_q.push_back(ctrl);
  endtask

  // Every handshake seen here completes on the following rising edge.
  always @(negedge CLK) begin
    if (RST_N && bus.ctrl_valid && bus.ctrl_ready) begin
      issue_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_word: got %0h expected no issue", bus.controlSignal);
      end else begin
        check("issue_word", 32'(bus.controlSignal), 32'(exp_q.pop_front()));
      end
    end
    if (RST_N && done) done_cnt++;
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_instr(input logic [7:0] rep, input logic [CW-1:0] ctrl);
    bus.instr_data  = {rep, ctrl};
    bus.instr_valid = 1'b1;
    @(negedge CLK);
    check("push_ready", 32'(bus.instr_ready), 32'd1);
    sb_push(rep, ctrl);
    cycle();
    bus.instr_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_stall, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      bus.ctrl_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge CLK);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    bus.ctrl_ready = 1'b1;
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},  32'(bus.controlSignal), 32'd0);
    check({tag, "_valid"}, 32'(bus.ctrl_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    rep;
    logic [CW-1:0] ctrl;
    bit            stall;
    int            exp_issues;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit got;
    int base_issue;
    int base_done;

    vecs[0] = '{rep: 8'd0,   ctrl: 6'o77, stall: 1'b0, exp_issues: 1};
    vecs[1] = '{rep: 8'd1,   ctrl: 6'o01, stall: 1'b0, exp_issues: 2};
    vecs[2] = '{rep: 8'd3,   ctrl: 6'o52, stall: 1'b1, exp_issues: 4};
    vecs[3] = '{rep: 8'd0,   ctrl: 6'o00, stall: 1'b1, exp_issues: 1};
    vecs[4] = '{rep: 8'd5,   ctrl: 6'o25, stall: 1'b1, exp_issues: 6};
    vecs[5] = '{rep: 8'd255, ctrl: 6'o44, stall: 1'b0, exp_issues: 256};
    vecs[6] = '{rep: 8'd17,  ctrl: 6'o63, stall: 1'b1, exp_issues: 18};

    RST_N = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.instr_data  = '0;
    bus.instr_valid = 1'b0;
    bus.ctrl_ready  = 1'b1;

    // Reset values, both while held and just after release before any edge.
    #12;
    check_reset_outputs("rst_held");
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_reset_outputs("rst_release");
    cycle();

    // Two-word sequence: one cycle of 12, three of 34, then a single done cycle.
    push_instr(8'd0, 6'o12);
    push_instr(8'd2, 6'o34);
    check("seq_count", 32'(count), 32'd2);
    start_pulse();
    @(negedge CLK);
    check("seq_c1_ctrl", 32'(bus.controlSignal), 32'(6'o12));
    check("seq_c1_valid", 32'(bus.ctrl_valid), 32'd1);
    check("seq_c1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("seq_b_ctrl", 32'(bus.controlSignal), 32'(6'o34));
      check("seq_b_valid", 32'(bus.ctrl_valid), 32'd1);
      check("seq_b_done", 32'(done), 32'd0);
    end
    @(negedge CLK);
    check("seq_done", 32'(done), 32'd1);
    check("seq_done_busy", 32'(busy), 32'd0);
    check("seq_done_valid", 32'(bus.ctrl_valid), 32'd0);
    check("seq_hold_ctrl", 32'(bus.controlSignal), 32'(6'o34));
    @(negedge CLK);
    check("seq_done_once", 32'(done), 32'd0);
    check("seq_idle", 32'(state_dbg), 32'd0);
    cycle();

    // Table-driven single-instruction runs.
    foreach (vecs[k]) begin
      base_issue = issue_cnt;
      push_instr(vecs[k].rep, vecs[k].ctrl);
      start_pulse();
      wait_done(1000, vecs[k].stall, got);
      check("tbl_done", 32'(got), 32'd1);
      check("tbl_issues", 32'(issue_cnt - base_issue), 32'(vecs[k].exp_issues));
      check("tbl_count", 32'(count), 32'd0);
      check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // Full queue: eight accepted, ninth refused, then drained in order.
    for (int i = 0; i < QD; i++) push_instr(8'd0, CW'(i * 5 + 3));
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(bus.instr_ready), 32'd0);
    bus.instr_data  = {8'd0, 6'o70};
    bus.instr_valid = 1'b1;
    cycle();
    bus.instr_valid = 1'b0;
    @(negedge CLK);
    check("full_refuse_count", 32'(count), 32'd8);
    cycle();
    base_issue = issue_cnt;
    start_pulse();
    wait_done(100, 1'b0, got);
    check("full_done", 32'(got), 32'd1);
    check("full_issues", 32'(issue_cnt - base_issue), 32'd8);
    check("full_drained", 32'(count), 32'd0);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // rep=1 with ready pattern 1,0,0,1.
    base_issue = issue_cnt;
    base_done  = done_cnt;
    push_instr(8'd1, 6'o63);
    start_pulse();
    @(negedge CLK);
    check("stall_c1_valid", 32'(bus.ctrl_valid), 32'd1);
    cycle();
    bus.ctrl_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("stall_hold_ctrl", 32'(bus.controlSignal), 32'(6'o63));
      check("stall_hold_valid", 32'(bus.ctrl_valid), 32'd1);
      check("stall_no_done", 32'(done), 32'd0);
      cycle();
    end
    bus.ctrl_ready = 1'b1;
    cycle();
    @(negedge CLK);
    check("stall_done", 32'(done), 32'd1);
    check("stall_issues", 32'(issue_cnt - base_issue), 32'd2);
    cycle();
    check("stall_done_cnt", 32'(done_cnt - base_done), 32'd1);

    // Push lands on the last issue of the last word: no done, new word follows.
    base_done = done_cnt;
    push_instr(8'd0, 6'o11);
    start_pulse();
    bus.instr_data  = {8'd0, 6'o22};
    bus.instr_valid = 1'b1;
    sb_push(8'd0, 6'o22);
    @(negedge CLK);
    check("late_push_ctrl", 32'(bus.controlSignal), 32'(6'o11));
    cycle();
    bus.instr_valid = 1'b0;
    @(negedge CLK);
    check("late_next_ctrl", 32'(bus.controlSignal), 32'(6'o22));
    check("late_next_valid", 32'(bus.ctrl_valid), 32'd1);
    check("late_no_done", 32'(done), 32'd0);
    check("late_busy", 32'(busy), 32'd1);
    cycle();
    @(negedge CLK);
    check("late_done", 32'(done), 32'd1);
    cycle();
    check("late_done_cnt", 32'(done_cnt - base_done), 32'd1);
    check("late_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort mid-run with three queued; the same-cycle push is discarded.
    bus.ctrl_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_instr(8'd0, CW'(6'o40 + i));
    start_pulse();
    @(negedge CLK);
    check("abort_pre_count", 32'(count), 32'd4);
    cycle();
    bus.ctrl_ready = 1'b1;
    cycle();
    bus.ctrl_ready = 1'b0;
    @(negedge CLK);
    check("abort_count3", 32'(count), 32'd3);
    check("abort_ctrl_next", 32'(bus.controlSignal), 32'(6'o41));
    cycle();
    base_done = done_cnt;
    abort = 1'b1;
    bus.instr_data  = {8'd0, 6'o55};
    bus.instr_valid = 1'b1;
    exp_q.delete();
    cycle();
    abort = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge CLK);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_valid", 32'(bus.ctrl_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    bus.ctrl_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    start_pulse();
    @(negedge CLK);
    check("empty_start_busy", 32'(busy), 32'd0);
    cycle();

    // Abort wins over start.
    push_instr(8'd0, 6'o07);
    start = 1'b1;
    abort = 1'b1;
    exp_q.delete();
    cycle();
    start = 1'b0;
    abort = 1'b0;
    @(negedge CLK);
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_count", 32'(count), 32'd0);
    cycle();

    // Asynchronous reset in the middle of a run.
    base_done = done_cnt;
    push_instr(8'd3, 6'o31);
    push_instr(8'd3, 6'o32);
    start_pulse();
    cycle();
    #2;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    cycle();
    cycle();
    check_reset_outputs("async_rst_hold");
    @(negedge CLK);
    RST_N = 1'b1;
    cycle();
    cycle();
    check("async_no_done", 32'(done_cnt - base_done), 32'd0);
    check("async_idle", 32'(busy), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
